// File: rtl/pwm_shadow.sv
// Edge-aligned PWM with a double-buffered duty register; new duty values land only on period boundaries.
// Defining PWMSHADOW_PRESC_EN builds a free-running prescaler that gates the count tick.
module pwm_shadow #(
    parameter int dutyBits  = 3,
    parameter int prescBits = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [dutyBits-1:0] duty,
    input  logic                duty_valid,
    output logic                duty_ready,
    output logic                out,
    output logic                period_start
);
    logic [dutyBits-1:0] r_cnt;
    logic [dutyBits-1:0] r_active;
    logic [dutyBits-1:0] r_shadow;
    logic                r_pending;
    logic                w_tick;
    logic                w_wrap;
    logic                w_accept;

`ifdef PWMSHADOW_PRESC_EN
    logic [prescBits-1:0] r_presc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = &r_presc;
`else
    // prescBits has no effect here; every clk is a count tick.
    assign w_tick = (prescBits > 0) || 1'b1;
`endif

    assign duty_ready = ~r_pending;
    assign w_accept   = duty_valid && !r_pending;
    assign w_wrap     = w_tick && (r_cnt == '1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt        <= '0;
            r_active     <= '0;
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            out          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
            out          <= (r_cnt < r_active);
            period_start <= w_tick && (r_cnt == '0);
            // A queued value wins at the wrap; with nothing queued, a same-cycle accept bypasses the shadow.
            if (w_wrap) begin
                if (r_pending) begin
                    r_active  <= r_shadow;
                    r_pending <= 1'b0;
                end else if (w_accept) begin
                    r_active <= duty;
                end
            end else if (w_accept) begin
                r_shadow  <= duty;
                r_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_shadow.sv
// Scoreboard bench for pwm_shadow: expected per-cycle out/period_start/duty_ready values are queued up front
// and a negedge monitor pops and compares them as the matching cycle arrives.
module tb_pwm_shadow;
    localparam int DW = 3;
`ifdef PWMSHADOW_PRESC_EN
    localparam int TPC = 4;
`else
    localparam int TPC = 1;
`endif

    logic          clk        = 1'b0;
    logic          rstn       = 1'b1;
    logic [DW-1:0] duty       = '0;
    logic          duty_valid = 1'b0;
    logic          duty_ready;
    logic          out;
    logic          period_start;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int mi;

    typedef struct {
        int   cyc;
        int   kind;
        logic val;
    } exp_t;
    exp_t sb[$];

    pwm_shadow #(.dutyBits(DW), .prescBits(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .duty        (duty),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .out         (out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int c, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, c, act, exp);
        end
    endtask

    function automatic void push(input int c, input int k, input logic v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endfunction

    // Expected waveform for n cycles of a period with duty d, starting at the cycle showing count 0.
    function automatic void push_period(input int start, input int d, input int n);
        for (int k = 0; k < n; k++) begin
            push(start + k, 0, ((k / TPC) < d));
            push(start + k, 1, (k == TPC - 1));
        end
    endfunction

    always @(negedge clk) begin
        mi = 0;
        while (mi < sb.size()) begin
            if (sb[mi].cyc == cyc) begin
                case (sb[mi].kind)
                    0:       check("out", cyc, out, sb[mi].val);
                    1:       check("period_start", cyc, period_start, sb[mi].val);
                    default: check("duty_ready", cyc, duty_ready, sb[mi].val);
                endcase
                sb.delete(mi);
            end else if (sb[mi].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missed_entry cyc=%0d actual=unchecked required=checked", sb[mi].cyc);
                sb.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        logic r;
        bit   done = 1'b0;
        duty       = d;
        duty_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            r = duty_ready;
            @(posedge clk);
            #1;
            if (r) done = 1'b1;
        end
        duty_valid = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout duty=%0d actual=not_accepted required=accepted", d);
        end
    endtask

    initial begin
`ifdef PWMSHADOW_PRESC_EN
        push_period(1, 0, 32);
        push_period(33, 4, 32);
        push_period(65, 4, 32);
        push(5, 2, 1'b1);  push(6, 2, 1'b0);  push(31, 2, 1'b0); push(32, 2, 1'b1);
`else
        push_period(1, 0, 8);   push_period(9, 3, 8);   push_period(17, 3, 8);
        push_period(25, 3, 8);  push_period(33, 0, 8);  push_period(41, 7, 8);
        push_period(49, 7, 8);  push_period(57, 7, 8);  push_period(65, 2, 8);
        push_period(73, 5, 8);  push_period(81, 5, 8);  push_period(89, 6, 8);
        push_period(97, 6, 8);  push_period(105, 6, 3);
        push_period(111, 0, 8); push_period(119, 0, 8);
        push(3, 2, 1'b1);   push(4, 2, 1'b0);   push(7, 2, 1'b0);   push(8, 2, 1'b1);
        push(27, 2, 1'b0);  push(31, 2, 1'b0);  push(32, 2, 1'b1);
        push(59, 2, 1'b0);  push(63, 2, 1'b0);  push(64, 2, 1'b1);
        push(65, 2, 1'b0);  push(71, 2, 1'b0);  push(72, 2, 1'b1);
        push(87, 2, 1'b1);  push(88, 2, 1'b1);  push(89, 2, 1'b1);
        push(107, 2, 1'b0); push(111, 2, 1'b1); push(120, 2, 1'b1);
`endif
        #1 rstn = 1'b0;
        #1;
        check("reset_out", cyc, out, 1'b0);
        check("reset_period_start", cyc, period_start, 1'b0);
        check("reset_duty_ready", cyc, duty_ready, 1'b1);
        #1 rstn = 1'b1;

`ifdef PWMSHADOW_PRESC_EN
        wait_cyc(5);
        send(3'd4);
        wait_cyc(100);
`else
        wait_cyc(3);
        send(3'd3);
        wait_cyc(26);
        send(3'd0);
        wait_cyc(34);
        send(3'd7);
        wait_cyc(58);
        send(3'd2);
        send(3'd5);
        wait_cyc(87);
        send(3'd6);
        wait_cyc(106);
        send(3'd1);
        wait_cyc(108);
        #2 rstn = 1'b0;
        #1;
        check("async_reset_out", cyc, out, 1'b0);
        check("async_reset_period_start", cyc, period_start, 1'b0);
        check("async_reset_duty_ready", cyc, duty_ready, 1'b1);
        wait_cyc(110);
        #2 rstn = 1'b1;
        wait_cyc(130);
`endif
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d_left required=0_left", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_shadow.md
# pwm_shadow

Edge-aligned PWM generator with a double-buffered duty register, sitting directly downstream of the LED brightness sequencers and driving the LED pins. A new duty value is accepted through a valid/ready handshake into a shadow register. It is applied only at a period boundary, so no PWM period ever mixes two duty values. The block also emits a one-cycle period-start pulse so upstream sequencers can pace their duty steps to whole PWM periods.

## Interface
- dutyBits, default 3: width of the duty value and of the PWM period counter; period is 2^dutyBits counts.
- prescBits, default 2: prescaler width; used only when PWMSHADOW_PRESC_EN is defined.
- clk  in  1  single clock; all state changes on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- duty  in  dutyBits  requested duty, unsigned; number of high counts per period.
- duty_valid  in  1  duty is presented; must hold duty stable until accepted.
- duty_ready  out  1  shadow register free; equals ~pending.
- out  out  1  registered PWM output, active-high.
- period_start  out  1  registered one-cycle pulse, high while out reflects count 0.

## Operation
- State: cnt[dutyBits], active[dutyBits], shadow[dutyBits], pending, out, period_start.
- Reset (rstn low, asynchronous): cnt=0, active=0, shadow=0, pending=0, out=0, period_start=0, so duty_ready=1. Any pending update is discarded.
- Count enable tick: every clk without the macro, and prescaler wrap with it.
- On each tick, cnt increments modulo 2^dutyBits. Wrap is the tick on which cnt=='1.
- Compare is unsigned: out is registered from (cnt < active); period_start is registered from (tick && cnt==0).
- Duty semantics:
  - duty 0: out constantly 0.
  - duty 2^dutyBits-1: out low for exactly 1 count per period.
  - There is no 100% mode.
- Handshake: an accept happens on a cycle with duty_valid && duty_ready.
  - Accept on a non-wrap cycle: shadow<=duty, pending<=1.
  - Wrap with pending=1: active<=shadow, pending<=0.
  - Accept on the wrap cycle (pending was 0): active<=duty directly (bypass); pending stays 0 and shadow is unchanged.
  - With pending=1, duty_ready=0, so there is no second accept. At most one queued update exists.
- duty is ignored when duty_valid is low, and ignored while duty_ready is low.

## Timing
- out and period_start lag cnt/active by one clk. Both are glitch-free register outputs.
- Update latency: an accepted duty governs the first period whose count 0 is registered after the next wrap.
  - Worst case is 2^dutyBits ticks plus 1 clk.
  - A wrap-cycle accept takes effect in the immediately following period.
- duty_ready rises in the clk after the wrap that consumes pending. It is combinational from pending only.
- period_start pulse width is exactly 1 clk, including when the prescaler is enabled.
- First cycle after rstn deassert: cnt=0 is reached at the first tick. The first registered period_start occurs 1 clk after that tick.

## Configuration
- PWMSHADOW_PRESC_EN defined:
  - A prescBits-wide free-running prescaler, reset to 0, gates tick; tick is high when the prescaler is '1.
  - The period becomes 2^(dutyBits+prescBits) clks.
  - Handshake and wrap rules operate on tick cycles; accepts may still occur on any clk.
- Macro undefined: no prescaler logic, tick=1 every clk, prescBits has no effect.

## Test plan
- Reset, then duty=3 (dutyBits=3) accepted mid-period: duty_ready drops next clk. After the next wrap, out is high 3 clks then low 5 clks per 8-clk period, repeating. duty_ready returns to 1 one clk after the wrap.
- Set duty=0, then duty=7: with duty 0, out stays 0 for a full period. With duty 7, out is high 7 clks and low 1 clk per period. period_start pulses every 8 clks, aligned with the first high count.
- Hold duty_valid with 5 while an update of 2 is pending: 5 is not accepted until duty_ready rises. Exactly one period uses duty 2, then the next period after the following wrap uses 5.
- Present duty=6 with duty_valid on exactly the wrap cycle, with pending=0: the very next period shows 6 high counts, and duty_ready never drops.
- Assert rstn low mid-period with pending=1: out=0, period_start=0 and duty_ready=1 immediately, without waiting for clk. After release the output is constantly 0 until a new accept.
- With PWMSHADOW_PRESC_EN defined, prescBits=2, duty=4: period is 32 clks, out is high 16 clks, and period_start is 1 clk wide every 32 clks.
